match_list_reader: RTL and testbench
====================================

# match_list_reader

Playback sequencer for the string-match search. Once the scan engine has filled the match-position memory, this block reads each stored entry in order and presents it for display. Each position is shown for one second and blanked for one second, so the display digits blink once per entry. It sits between the match-position memory read port and the two-digit position display, and is the reading end of the memory that the scan engine writes.

## Interface
Parameters:
- FREQUENCY, 100_000_000, clk cycles per 1 s blink half-period
- ADDR_W, 6, memory address width (depth 2^ADDR_W)
- DATA_W, 8, stored position width

Ports:
- clk  in  1  clock; all registers update on the falling edge
- reset  in  1  reset, synchronous, active-low
- start  in  1  level; high = scan complete, entries valid
- count  in  ADDR_W+1  number of valid entries (0..2^ADDR_W)
- roll_back  in  1  active-low button; press restarts playback at entry 0
- rd_addr  out  ADDR_W  memory read address
- rd_data  in  DATA_W  memory read data, valid one clk after rd_addr
- pos_out  out  DATA_W  currently presented position
- pos_valid  out  1  high = display pos_out, low = blank
- busy  out  1  high in any state other than IDLE and EMPTY
- empty  out  1  high while start is high and count was 0 when sampled
- wrap  out  1  one-cycle pulse when playback returns from the last entry to entry 0

## Operation
- Reset (reset=0 at an edge): state IDLE; pos_out=0, pos_valid=0, rd_addr=0, busy=0, empty=0, wrap=0; idx=0; tick counter=0; roll_back edge detector primed to 1 (released).
- count is latched into cnt_q on the IDLE exit; later changes to count are ignored until the block returns to IDLE.
- IDLE:
  - start=1 and count≠0 -> FETCH, idx=0.
  - start=1 and count=0 -> EMPTY.
- EMPTY: empty=1, pos_valid=0; start=0 -> IDLE.
- FETCH (exactly 2 cycles):
  - cycle 1 drives rd_addr=idx.
  - cycle 2 latches pos_out<=rd_data, then -> ON.
- ON: pos_valid=1 for FREQUENCY cycles -> OFF.
- OFF: pos_valid=0 for FREQUENCY cycles, then:
  - idx==cnt_q-1 -> idx=0, wrap pulse, FETCH.
  - otherwise idx+1, FETCH.
- roll_back falling edge, detected on a registered copy, in FETCH/ON/OFF: idx=0, tick counter=0, pos_valid=0, -> FETCH. A held button gives exactly one restart.
- start=0 in any non-IDLE state: -> IDLE next edge; pos_valid=0; pos_out holds its last value.
- Priority, highest first: reset > start=0 > roll_back > normal sequencing. roll_back coinciding with OFF expiry at the last entry restarts at 0 with no wrap pulse.
- idx arithmetic is ADDR_W+1 bits so that cnt_q=2^ADDR_W does not overflow; rd_addr takes the low ADDR_W bits.
- The tick counter is $clog2(FREQUENCY) bits, counts 0..FREQUENCY-1, and clears on every state change.

## Timing
- start rises with count≠0: rd_addr=0 on edge 1, pos_out valid and pos_valid=1 on edge 3.
- Per-entry period = 2 + 2·FREQUENCY cycles.
- roll_back press registered on edge k: FETCH on k+1, pos_valid=1 on k+3.
- wrap is asserted for the single cycle entering FETCH for idx 0 after the last entry.
- Minimum FREQUENCY is 1.

## Structure
- Shared package find_string_pkg holds:
  - state encoding localparams: IDLE, EMPTY, FETCH, ON, OFF (one-hot, 5 bits), matching the NHAP/XOA/XUAT one-hot style;
  - the default FREQUENCY constant.
- One sub-module, blink_tick_gen: a parameterised FREQUENCY down-counter with synchronous clear, producing a one-cycle expire pulse. The FSM, idx register and roll_back edge detect stay in the top module.

## Test plan
All scenarios use FREQUENCY=4, memory {0:3, 1:7, 2:12}, count=3.
- Basic playback: release reset, start=1 -> pos_out sequence 3,7,12,3 with pos_valid high 4 and low 4 cycles per entry; wrap pulses once before the second 3.
- Empty list: count=0, start=1 -> empty=1, busy=0, pos_valid stays 0, rd_addr stays 0.
- Roll_back: press during ON of entry 7 -> the next FETCH reads addr 0 and pos_out=3 two cycles later. Holding the button 20 cycles gives a single restart.
- Simultaneous events: roll_back press on the last OFF expiry cycle of entry 12 -> FETCH addr 0, no wrap pulse.
- Reset mid-operation: reset=0 during ON of entry 7 -> next edge all outputs at reset values. With start still 1 after release -> playback restarts at 3.
- Latched count: change count to 1 while playing -> the sequence still wraps after 12. Drop start, raise it again -> only 3 repeats, with wrap on each cycle.

Source files
------------

// File: rtl/find_string_pkg.sv
// Shared definitions for the string-match search: one-hot playback states
// and the default blink half-period in clock cycles.
package find_string_pkg;

  localparam int DEFAULT_FREQUENCY = 100_000_000;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    EMPTY = 5'b00010,
    FETCH = 5'b00100,
    ON    = 5'b01000,
    OFF   = 5'b10000
  } state_t;

endpackage

// File: rtl/blink_tick_gen.sv
// Blink half-period timer: down-counter reloaded on clear, one-cycle expire
// pulse on the last cycle of each FREQUENCY-cycle window while enabled.
module blink_tick_gen
  import find_string_pkg::*;
#(
  parameter int FREQUENCY = DEFAULT_FREQUENCY
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = (FREQUENCY > 1) ? $clog2(FREQUENCY) : 1;
  localparam logic [CW-1:0] LOAD = CW'(FREQUENCY - 1);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == '0);

  always_ff @(negedge clk) begin
    if (!reset) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (en) begin
      cnt <= expire ? LOAD : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/match_list_reader.sv
// Plays back the stored match positions in order, each shown for one blink
// half-period and blanked for the next; roll_back restarts at entry 0.
module match_list_reader
  import find_string_pkg::*;
#(
  parameter int FREQUENCY = DEFAULT_FREQUENCY,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  input  logic              roll_back,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] pos_out,
  output logic              pos_valid,
  output logic              busy,
  output logic              empty,
  output logic              wrap
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_t state, state_next;
  logic [ADDR_W:0] idx, idx_next, cnt_q;
  logic fetch_ph, ph_next, wrap_next, load_pos, tick_clr, expire;
  logic rb_q, rb_d, rb_fall;

  assign rb_fall   = rb_d & ~rb_q;
  assign rd_addr   = idx[ADDR_W-1:0];
  assign pos_valid = (state == ON);
  assign empty     = (state == EMPTY);
  assign busy      = (state == FETCH) || (state == ON) || (state == OFF);

  blink_tick_gen #(.FREQUENCY(FREQUENCY)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (tick_clr),
    .en     (pos_valid || (state == OFF)),
    .expire (expire)
  );

  always_comb begin
    state_next = state;
    idx_next   = idx;
    ph_next    = 1'b0;
    wrap_next  = 1'b0;
    load_pos   = 1'b0;
    tick_clr   = 1'b0;
    if (state != IDLE && !start) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              state_next = FETCH;
              idx_next   = '0;
            end else begin
              state_next = EMPTY;
            end
          end
        end
        EMPTY: ;
        default: begin
          // restart also covers being in FETCH already, where state does not change
          if (rb_fall) begin
            state_next = FETCH;
            idx_next   = '0;
            tick_clr   = 1'b1;
          end else begin
            case (state)
              FETCH: begin
                if (fetch_ph) begin
                  load_pos   = 1'b1;
                  state_next = ON;
                end else begin
                  ph_next = 1'b1;
                end
              end
              ON: if (expire) state_next = OFF;
              OFF: begin
                if (expire) begin
                  state_next = FETCH;
                  if (idx == cnt_q - ONE) begin
                    idx_next  = '0;
                    wrap_next = 1'b1;
                  end else begin
                    idx_next = idx + ONE;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
    tick_clr = tick_clr | (state_next != state);
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      cnt_q    <= '0;
      fetch_ph <= 1'b0;
      pos_out  <= '0;
      wrap     <= 1'b0;
      rb_q     <= 1'b1;
      rb_d     <= 1'b1;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      fetch_ph <= ph_next;
      wrap     <= wrap_next;
      rb_q     <= roll_back;
      rb_d     <= rb_q;
      if (state == IDLE) cnt_q <= count;
      if (load_pos) pos_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_match_list_reader.sv
// Scoreboard bench for match_list_reader: expected positions are queued as
// stimulus is applied and checked on each rising edge of pos_valid.
module tb_match_list_reader;

  logic       clk = 1'b0;
  logic       reset, start, roll_back;
  logic [6:0] count;
  logic [5:0] rd_addr;
  logic [7:0] rd_data = 8'd0;
  logic [7:0] pos_out;
  logic       pos_valid, busy, empty, wrap;

  logic [7:0] mem [64];
  logic [7:0] sb [$];
  int total = 0, bad = 0;
  int wrap_cnt = 0, hi_len = 0, lo_len = 0;
  logic pv_prev = 1'b0, len_chk = 1'b0, seen_fall = 1'b0;

  always #5 clk = ~clk;

  match_list_reader #(.FREQUENCY(4), .ADDR_W(6), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .roll_back (roll_back),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pos_out   (pos_out),
    .pos_valid (pos_valid),
    .busy      (busy),
    .empty     (empty),
    .wrap      (wrap)
  );

  always @(negedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (pos_valid && !pv_prev) begin
      if (len_chk && seen_fall) chk("off_len", lo_len, 6);
      hi_len = 1;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("pos_out", pos_out, sb.pop_front());
    end else if (pos_valid) begin
      hi_len++;
    end else if (pv_prev) begin
      if (len_chk) chk("on_len", hi_len, 4);
      seen_fall = 1'b1;
      lo_len = 1;
    end else begin
      lo_len++;
    end
    if (wrap) begin
      wrap_cnt++;
      chk("wrap_addr", rd_addr, 0);
    end
    pv_prev = pos_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic reset_dut();
    reset = 1'b0; start = 1'b0; roll_back = 1'b1;
    step(3);
    reset = 1'b1;
    step(1);
    sb.delete();
    wrap_cnt = 0;
  endtask

  task automatic wait_sb(input string tag, input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic wait_on(input logic [7:0] v, input int bound);
    int n = 0;
    while (!(pos_valid && pos_out == v) && n < bound) begin
      @(posedge clk);
      n++;
    end
    chk("wait_on", (n < bound) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'hEE;
    mem[0] = 8'd3; mem[1] = 8'd7; mem[2] = 8'd12;
    count = 7'd3;

    // reset values
    reset_dut();
    reset = 1'b0;
    step(2);
    chk("rst_pos_out", pos_out, 0);
    chk("rst_pos_valid", pos_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 0);
    chk("rst_wrap", wrap, 0);
    reset = 1'b1;
    step(1);

    // basic playback
    sb.push_back(8'd3); sb.push_back(8'd7); sb.push_back(8'd12); sb.push_back(8'd3);
    len_chk = 1'b1; seen_fall = 1'b0;
    start = 1'b1;
    step(1);
    chk("fetch_addr", rd_addr, 0);
    chk("fetch_busy", busy, 1);
    chk("fetch_pv1", pos_valid, 0);
    step(1);
    chk("fetch_pv2", pos_valid, 0);
    step(1);
    chk("first_pv", pos_valid, 1);
    wait_sb("basic_done", 60);
    len_chk = 1'b0;
    chk("basic_wrap", wrap_cnt, 1);
    start = 1'b0;
    step(1);
    chk("stop_pv", pos_valid, 0);
    chk("stop_busy", busy, 0);
    chk("stop_hold", pos_out, 3);

    // empty list
    reset_dut();
    count = 7'd0;
    start = 1'b1;
    step(3);
    chk("empty_flag", empty, 1);
    chk("empty_busy", busy, 0);
    chk("empty_pv", pos_valid, 0);
    chk("empty_addr", rd_addr, 0);
    start = 1'b0;
    step(1);
    chk("empty_clr", empty, 0);

    // roll_back during ON of 7, held 20 cycles
    reset_dut();
    count = 7'd3;
    sb.push_back(8'd3); sb.push_back(8'd7);
    start = 1'b1;
    wait_on(8'd7, 40);
    sb.push_back(8'd3); sb.push_back(8'd7);
    roll_back = 1'b0;
    step(2);
    chk("rb_addr", rd_addr, 0);
    chk("rb_pv", pos_valid, 0);
    step(18);
    roll_back = 1'b1;
    wait_sb("rb_done", 20);
    start = 1'b0;
    step(2);

    // roll_back on OFF expiry of the last entry: restart without wrap
    reset_dut();
    sb.push_back(8'd3); sb.push_back(8'd7); sb.push_back(8'd12); sb.push_back(8'd3);
    start = 1'b1;
    wait_on(8'd12, 40);
    step(6);
    roll_back = 1'b0;
    step(2);
    chk("sim_addr", rd_addr, 0);
    chk("sim_busy", busy, 1);
    wait_sb("sim_done", 20);
    chk("sim_wrap", wrap_cnt, 0);
    roll_back = 1'b1;
    start = 1'b0;
    step(2);

    // reset during ON of 7, start held
    reset_dut();
    sb.push_back(8'd3); sb.push_back(8'd7);
    start = 1'b1;
    wait_on(8'd7, 40);
    reset = 1'b0;
    step(1);
    chk("mid_pos_out", pos_out, 0);
    chk("mid_pv", pos_valid, 0);
    chk("mid_addr", rd_addr, 0);
    chk("mid_busy", busy, 0);
    sb.push_back(8'd3);
    reset = 1'b1;
    wait_sb("mid_restart", 20);
    start = 1'b0;
    step(2);

    // count latched on IDLE exit
    reset_dut();
    sb.push_back(8'd3); sb.push_back(8'd7); sb.push_back(8'd12); sb.push_back(8'd3);
    start = 1'b1;
    wait_on(8'd3, 20);
    count = 7'd1;
    wait_sb("latch_done", 60);
    chk("latch_wrap", wrap_cnt, 1);
    start = 1'b0;
    step(2);
    wrap_cnt = 0;
    sb.push_back(8'd3); sb.push_back(8'd3); sb.push_back(8'd3);
    start = 1'b1;
    wait_sb("one_done", 60);
    chk("one_wrap", wrap_cnt, 2);
    start = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
